// File: rtl/bellek_paket.sv
// Shared definitions for the memory arbiter: FSM states, default timeout and abort data.
package bellek_paket;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } durum_t;

    localparam int unsigned VARSAYILAN_TIMEOUT = 255;
    localparam logic [31:0] IPTAL_VERISI       = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_hakem_2.sv
// Two-input round-robin grant decision; the last-grant pointer lives in the caller.
module rr_hakem_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // A lone requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bellek_hakemi.sv
// Memory arbiter: shares one iomem port between the instruction cache (m0) and the
// data cache (m1), with a per-transaction wait limit and a sticky timeout flag.
module bellek_hakemi
    import bellek_paket::*;
#(
    parameter int unsigned TIMEOUT = VARSAYILAN_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        m0_busy,
    output logic        m1_busy,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [31:0] iomem_addr,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_write_data,
    input  logic [31:0] iomem_read_data,

    output logic        timeout_err
);

    // Counter only needs to reach TIMEOUT-1: the abort fires on the edge it would hit TIMEOUT.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_SON = CNT_W'(TIMEOUT - 1);

    durum_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             owner;
    logic             last_grant;

    logic             grant_valid;
    logic             grant_idx;
    logic [31:0]      sel_addr;
    logic [3:0]       sel_wstrb;
    logic [31:0]      sel_wdata;

    rr_hakem_2 u_rr_hakem_2 (
        .req         ({m1_valid, m0_valid}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Route the winning requester's command toward the iomem registers.
    always_comb begin
        sel_addr  = grant_idx ? m1_addr  : m0_addr;
        sel_wstrb = grant_idx ? m1_wstrb : m0_wstrb;
        sel_wdata = grant_idx ? m1_wdata : m0_wdata;
    end

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            owner            <= 1'b0;
            last_grant       <= 1'b0;
            iomem_valid      <= 1'b0;
            iomem_addr       <= '0;
            iomem_wstrb      <= '0;
            iomem_write_data <= '0;
            m0_ready         <= 1'b0;
            m1_ready         <= 1'b0;
            m0_rdata         <= '0;
            m1_rdata         <= '0;
            m0_busy          <= 1'b0;
            m1_busy          <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        iomem_valid      <= 1'b1;
                        iomem_addr       <= sel_addr;
                        iomem_wstrb      <= sel_wstrb;
                        iomem_write_data <= sel_wdata;
                        wait_cnt         <= '0;
                        owner            <= grant_idx;
                        last_grant       <= grant_idx;
                        m0_busy          <= grant_idx;
                        m1_busy          <= ~grant_idx;
                        state            <= SERVE;
                    end
                end
                SERVE: begin
                    // A reply in the timeout cycle still counts as a normal completion.
                    if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        if (owner) begin
                            m1_rdata <= iomem_read_data;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= iomem_read_data;
                            m0_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else if (wait_cnt == CNT_SON) begin
                        iomem_valid <= 1'b0;
                        timeout_err <= 1'b1;
                        if (owner) begin
                            m1_rdata <= IPTAL_VERISI;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= IPTAL_VERISI;
                            m0_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    m0_busy  <= 1'b0;
                    m1_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Self-checking bench for bellek_hakemi: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin pointer, reply latency, sticky error).
module tb_bellek_hakemi;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready, m0_busy, m1_busy;
    logic [31:0] m0_rdata, m1_rdata;
    logic        iomem_valid, iomem_ready;
    logic [31:0] iomem_addr, iomem_write_data, iomem_read_data;
    logic [3:0]  iomem_wstrb;
    logic        timeout_err;

    bellek_hakemi #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_valid         (m0_valid),
        .m0_addr          (m0_addr),
        .m0_wstrb         (m0_wstrb),
        .m0_wdata         (m0_wdata),
        .m0_ready         (m0_ready),
        .m0_rdata         (m0_rdata),
        .m1_valid         (m1_valid),
        .m1_addr          (m1_addr),
        .m1_wstrb         (m1_wstrb),
        .m1_wdata         (m1_wdata),
        .m1_ready         (m1_ready),
        .m1_rdata         (m1_rdata),
        .m0_busy          (m0_busy),
        .m1_busy          (m1_busy),
        .iomem_valid      (iomem_valid),
        .iomem_ready      (iomem_ready),
        .iomem_addr       (iomem_addr),
        .iomem_wstrb      (iomem_wstrb),
        .iomem_write_data (iomem_write_data),
        .iomem_read_data  (iomem_read_data),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          last_g;
    logic [31:0] exp_rd [2];
    logic        exp_terr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic iov, input logic r0, input logic r1,
                             input logic b0, input logic b1);
        chk({tag, " iomem_valid"}, {31'd0, iomem_valid}, {31'd0, iov});
        chk({tag, " m0_ready"}, {31'd0, m0_ready}, {31'd0, r0});
        chk({tag, " m1_ready"}, {31'd0, m1_ready}, {31'd0, r1});
        chk({tag, " m0_busy"}, {31'd0, m0_busy}, {31'd0, b0});
        chk({tag, " m1_busy"}, {31'd0, m1_busy}, {31'd0, b1});
        chk({tag, " m0_rdata"}, m0_rdata, exp_rd[0]);
        chk({tag, " m1_rdata"}, m1_rdata, exp_rd[1]);
        chk({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, exp_terr});
    endtask

    task automatic model_reset();
        last_g    = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_terr  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        iomem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        chk_state(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " iomem_addr"}, iomem_addr, 32'd0);
        chk({tag, " iomem_wstrb"}, {28'd0, iomem_wstrb}, 32'd0);
        chk({tag, " iomem_write_data"}, iomem_write_data, 32'd0);
    endtask

    task automatic idle_cycle();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        @(posedge clk); #1;
        chk_state("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One transaction: entered and left at #1 after an edge with the arbiter idle.
    // lat = SERVE cycle index on which the memory replies; lat >= TO means never.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int lat, input bit keep_loser, input logic [31:0] rdv);
        int          w;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        bit          replied;
        m0_valid = v0; m0_addr = a0; m0_wstrb = s0; m0_wdata = d0;
        m1_valid = v1; m1_addr = a1; m1_wstrb = s1; m1_wdata = d1;
        if (v0 && v1) w = 1 - last_g;
        else w = v1 ? 1 : 0;
        ea = (w == 1) ? a1 : a0;
        es = (w == 1) ? s1 : s0;
        ed = (w == 1) ? d1 : d0;
        @(posedge clk); #1;
        last_g = w;
        // Winner withdraws and scribbles over its inputs; the latched command must not move.
        if (w == 1) begin
            m1_valid = 1'b0; m1_addr = $urandom; m1_wstrb = 4'($urandom); m1_wdata = $urandom;
        end else begin
            m0_valid = 1'b0; m0_addr = $urandom; m0_wstrb = 4'($urandom); m0_wdata = $urandom;
        end
        if (!keep_loser) begin
            m0_valid = 1'b0;
            m1_valid = 1'b0;
        end
        replied = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            chk_state("serve", 1'b1, 1'b0, 1'b0, w == 1, w == 0);
            chk("serve iomem_addr", iomem_addr, ea);
            chk("serve iomem_wstrb", {28'd0, iomem_wstrb}, {28'd0, es});
            chk("serve iomem_write_data", iomem_write_data, ed);
            iomem_ready = (k == lat);
            iomem_read_data = (k == lat) ? rdv : $urandom;
            @(posedge clk); #1;
            iomem_ready = 1'b0;
            iomem_read_data = $urandom;
            if (k == lat) begin
                replied = 1'b1;
                break;
            end
        end
        exp_rd[w] = replied ? rdv : 32'hFFFF_FFFF;
        if (!replied) exp_terr = 1'b1;
        chk_state("done", 1'b0, w == 0, w == 1, w == 1, w == 0);
        @(posedge clk); #1;
        chk_state("back-idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
        iomem_ready = 1'b0; iomem_read_data = '0;
        model_reset();
        do_reset("reset");

        // Both valid right after reset: m1 first, then the still-waiting m0.
        run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0, 4'h3,
                32'h1111_1111, 32'h2222_2222, 2, 1'b1, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 4'h0,
                32'h1111_1111, 32'h0, 1, 1'b0, 32'h8765_4321);

        // m1 read at 0x400, reply after 3 SERVE cycles.
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0400, 4'h0, 4'h0,
                32'h0, 32'h0, 3, 1'b0, 32'hA5A5_0001);

        // m0 full-word write.
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 4'h0,
                32'hDEAD_BEEF, 32'h0, 4, 1'b0, 32'h0BAD_F00D);

        // Reply on the very last allowed cycle: normal completion, no error.
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_0800, 4'h0, 4'h0,
                32'h0, 32'h0, int'(TO) - 1, 1'b0, 32'hCAFE_0007);

        // Memory never answers: abort with all-ones data, sticky error.
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 4'h0,
                32'h0, 32'h0, 1000, 1'b0, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int v;
            v = int'($urandom_range(1, 3));
            run_txn(v[0], v[1], $urandom, $urandom, 4'($urandom), 4'($urandom),
                    $urandom, $urandom, int'($urandom_range(0, 10)), 1'b0, $urandom);
            if (v == 3) idle_cycle();
        end

        // Reset in the middle of SERVE: aborted with no ready pulse.
        m0_valid = 1'b1; m0_addr = 32'h0000_0044; m0_wstrb = 4'h1; m0_wdata = 32'h55;
        @(posedge clk); #1;
        m0_valid = 1'b0;
        chk("mid serve iomem_valid", {31'd0, iomem_valid}, 32'd1);
        @(posedge clk); #1;
        do_reset("mid reset");
        idle_cycle();

        // After that reset the last-grant pointer is back at m0, so m1 wins the tie.
        run_txn(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0304, 4'h0, 4'h0,
                32'h0, 32'h0, 0, 1'b1, 32'h0000_0304);
        run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 4'h0,
                32'h0, 32'h0, 5, 1'b0, 32'h0000_0300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
